// File: rtl/double_frame_buffer.sv
// Double-buffered frame store: two pixel banks, one shown (front) and one
// drawn into (back). Bank exchange is deferred to vertical blank and is
// blocked while a hardware fill of the back bank is running.
module double_frame_buffer #(
    parameter int PIX_W  = 16,
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [PIX_W-1:0]  write_pixel,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              swap_req,
    input  logic              frame_start,
    input  logic              clear_req,
    input  logic [PIX_W-1:0]  clear_color,
    output logic [PIX_W-1:0]  vga_pixel,
    output logic              front_sel,
    output logic              busy,
    output logic              swap_pending,
    output logic              swap_done
);

    localparam int                DEPTH     = H_RES * V_RES;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Widened by one bit so the range check also works when 2^ADDR_W == DEPTH.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [PIX_W-1:0]    clr_color_q;
    logic                front_sel_q;
    logic                swap_pending_q;
    logic                swap_done_q;
    logic [PIX_W-1:0]    vga_pixel_q;

    // Pixel storage is deliberately left without reset: a reset must not
    // disturb the picture, and an aborted fill stays partially applied.
    logic [PIX_W-1:0]    bank0_q [DEPTH];
    logic [PIX_W-1:0]    bank1_q [DEPTH];

    logic                wr_en_d;
    logic [IDX_W-1:0]    wr_idx_d;
    logic [PIX_W-1:0]    wr_data_d;
    logic                wr_in_range_d;
    logic                rd_in_range_d;

    assign wr_in_range_d = ({1'b0, write_addr} < DEPTH_X);
    assign rd_in_range_d = ({1'b0, read_addr} < DEPTH_X);

    // Clear FSM: accepts a fill request only when idle, then walks the back bank once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_req) begin
                        state_q     <= ST_CLEAR;
                        busy_q      <= 1'b1;
                        clr_cnt_q   <= '0;
                        clr_color_q <= clear_color;
                    end else begin
                        busy_q      <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    clr_cnt_q <= '0;
                end
            endcase
        end
    end

    // Swap control: latch a request, execute it at the first vertical blank with no fill running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
        end else begin
            swap_done_q <= 1'b0;
            if (swap_pending_q && frame_start && !busy_q) begin
                front_sel_q    <= ~front_sel_q;
                swap_pending_q <= 1'b0;
                swap_done_q    <= 1'b1;
            end else if (swap_req) begin
                swap_pending_q <= 1'b1;
            end else begin
                swap_pending_q <= swap_pending_q;
            end
        end
    end

    // Back-bank write source: the fill engine owns the port while busy, else the user write.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_idx_d  = '0;
        wr_data_d = '0;
        if (reset) begin
            wr_en_d = 1'b0;
        end else if (busy_q) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = clr_cnt_q[IDX_W-1:0];
            wr_data_d = clr_color_q;
        end else if (we && wr_in_range_d) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = write_addr[IDX_W-1:0];
            wr_data_d = write_pixel;
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Memory write: only ever the bank that is not being displayed.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            if (front_sel_q) begin
                bank0_q[wr_idx_d] <= wr_data_d;
            end else begin
                bank1_q[wr_idx_d] <= wr_data_d;
            end
        end
    end

    // Display read: one-cycle latency from the registered front bank; out-of-range reads give zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_pixel_q <= '0;
        end else if (rd_in_range_d) begin
            vga_pixel_q <= front_sel_q ? bank1_q[read_addr[IDX_W-1:0]]
                                       : bank0_q[read_addr[IDX_W-1:0]];
        end else begin
            vga_pixel_q <= '0;
        end
    end

    assign vga_pixel    = vga_pixel_q;
    assign front_sel    = front_sel_q;
    assign busy         = busy_q;
    assign swap_pending = swap_pending_q;
    assign swap_done    = swap_done_q;

endmodule

// File: tb/tb_double_frame_buffer.sv
// Scoreboard bench for double_frame_buffer, run on a reduced 12x10 frame so a
// full fill fits comfortably in simulation time.
module tb_double_frame_buffer;

    localparam int PIX_W  = 16;
    localparam int H_RES  = 12;
    localparam int V_RES  = 10;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = H_RES * V_RES;
    localparam int AMAX   = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              we = 1'b0;
    logic [PIX_W-1:0]  write_pixel = '0;
    logic [ADDR_W-1:0] write_addr = '0;
    logic [ADDR_W-1:0] read_addr = '0;
    logic              swap_req = 1'b0;
    logic              frame_start = 1'b0;
    logic              clear_req = 1'b0;
    logic [PIX_W-1:0]  clear_color = '0;
    logic [PIX_W-1:0]  vga_pixel;
    logic              front_sel;
    logic              busy;
    logic              swap_pending;
    logic              swap_done;

    double_frame_buffer #(
        .PIX_W(PIX_W), .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .write_pixel(write_pixel),
        .write_addr(write_addr), .read_addr(read_addr), .swap_req(swap_req),
        .frame_start(frame_start), .clear_req(clear_req), .clear_color(clear_color),
        .vga_pixel(vga_pixel), .front_sel(front_sel), .busy(busy),
        .swap_pending(swap_pending), .swap_done(swap_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PIX_W-1:0] vga;
        bit               vga_chk;
        bit               fs;
        bit               busy;
        bit               pend;
        bit               done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: plain arrays of pixels per bank plus a few flags.
    logic [PIX_W-1:0] m_mem   [2][DEPTH];
    bit               m_known [2][DEPTH];
    bit               m_front = 1'b0;
    bit               m_pend  = 1'b0;
    bit               m_done  = 1'b0;
    int               m_clr_left = 0;
    int               m_clr_pos  = 0;
    logic [PIX_W-1:0] m_clr_col  = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step(output exp_t e);
        int f;
        int bk;
        int ra;
        int wa;
        bit b;
        f  = m_front ? 1 : 0;
        bk = 1 - f;
        ra = int'(read_addr);
        wa = int'(write_addr);
        b  = (m_clr_left > 0);
        if (ra < DEPTH) begin
            e.vga     = m_mem[f][ra];
            e.vga_chk = m_known[f][ra];
        end else begin
            e.vga     = '0;
            e.vga_chk = 1'b1;
        end
        if (b) begin
            m_mem[bk][m_clr_pos]   = m_clr_col;
            m_known[bk][m_clr_pos] = 1'b1;
            m_clr_pos++;
            m_clr_left--;
        end else if (we && wa < DEPTH) begin
            m_mem[bk][wa]   = write_pixel;
            m_known[bk][wa] = 1'b1;
        end
        if (!b && clear_req) begin
            m_clr_left = DEPTH;
            m_clr_pos  = 0;
            m_clr_col  = clear_color;
        end
        m_done = 1'b0;
        if (m_pend && frame_start && !b) begin
            m_front = ~m_front;
            m_pend  = 1'b0;
            m_done  = 1'b1;
        end else if (swap_req) begin
            m_pend = 1'b1;
        end
        e.fs   = m_front;
        e.busy = (m_clr_left > 0);
        e.pend = m_pend;
        e.done = m_done;
    endtask

    // One clock of stimulus: record the expectation, wait for the edge, drop pulses.
    task automatic tick();
        exp_t e;
        model_step(e);
        exp_q.push_back(e);
        @(negedge clk);
        we          = 1'b0;
        swap_req    = 1'b0;
        frame_start = 1'b0;
        clear_req   = 1'b0;
    endtask

    task automatic rd(input int a);
        read_addr = ADDR_W'(a);
        tick();
    endtask

    task automatic check_reset_outputs();
        chk("rst_vga_pixel", 32'(vga_pixel), 32'h0);
        chk("rst_front_sel", 32'(front_sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_swap_pending", 32'(swap_pending), 32'h0);
        chk("rst_swap_done", 32'(swap_done), 32'h0);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        m_front    = 1'b0;
        m_pend     = 1'b0;
        m_done     = 1'b0;
        m_clr_left = 0;
        m_clr_pos  = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare every DUT output against the oldest pending expectation.
    always @(posedge clk) begin
        #1;
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.vga_chk) chk("vga_pixel", 32'(vga_pixel), 32'(mon_e.vga));
            chk("front_sel", 32'(front_sel), 32'(mon_e.fs));
            chk("busy", 32'(busy), 32'(mon_e.busy));
            chk("swap_pending", 32'(swap_pending), 32'(mon_e.pend));
            chk("swap_done", 32'(swap_done), 32'(mon_e.done));
        end
    end

    initial begin
        #1;
        reset = 1'b1;
        #2;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Fill bank 1 with 0x001F while hammering the write port (all dropped).
        clear_color = 16'h001F;
        clear_req   = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            we          = 1'b1;
            write_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            write_pixel = PIX_W'($urandom);
            read_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
            tick();
        end
        swap_req = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();
        rd(0);
        rd(DEPTH - 1);
        rd(0);

        // Fill bank 0, then swap back; request and blank together only arm the swap.
        clear_color = PIX_W'($urandom);
        clear_req   = 1'b1;
        tick();
        repeat (DEPTH) tick();
        swap_req    = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();

        // Isolation: write to back address 10, display still shows front value.
        we = 1'b1; write_addr = 8'd10; write_pixel = 16'h07E0; read_addr = 8'd10;
        tick();
        rd(10);
        rd(10);

        // Write 0xF800 to back address 5, swap, read it from the new front.
        we = 1'b1; write_addr = 8'd5; write_pixel = 16'hF800;
        tick();
        swap_req = 1'b1;
        tick();
        frame_start = 1'b1; read_addr = 8'd5;
        tick();
        rd(5);
        rd(10);

        // Clear and swap accepted together; blanks during the fill are deferred.
        clear_color = PIX_W'($urandom);
        clear_req = 1'b1; swap_req = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();
        repeat (DEPTH - 2) tick();
        frame_start = 1'b1;
        tick();
        tick();
        frame_start = 1'b1;
        tick();
        tick();

        // Out-of-range write and read.
        we = 1'b1; write_addr = ADDR_W'(DEPTH); write_pixel = 16'hDEAD; read_addr = ADDR_W'(DEPTH);
        tick();
        we = 1'b1; write_addr = ADDR_W'(AMAX); write_pixel = 16'hBEEF; read_addr = ADDR_W'(AMAX);
        tick();
        rd(DEPTH);

        // Reset after 100 fill cycles, then sweep both banks.
        clear_color = 16'hABCD;
        clear_req   = 1'b1;
        tick();
        repeat (100) tick();
        do_reset();
        for (int a = 0; a < DEPTH; a++) rd(a);
        swap_req = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();
        for (int a = 0; a < DEPTH; a++) rd(a);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            we          = ($urandom_range(0, 1) == 1);
            write_addr  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(DEPTH, AMAX))
                                                      : ADDR_W'($urandom_range(0, DEPTH - 1));
            write_pixel = PIX_W'($urandom);
            read_addr   = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(DEPTH, AMAX))
                                                      : ADDR_W'($urandom_range(0, DEPTH - 1));
            swap_req    = ($urandom_range(0, 19) == 0);
            frame_start = ($urandom_range(0, 9) == 0);
            clear_req   = ($urandom_range(0, 99) == 0);
            clear_color = PIX_W'($urandom);
            tick();
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
